regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 32: data bits per register.
REQ-002 Parameter NREGS, default 32: number of registers, legal range 2..256.
REQ-003 Parameter AW, default $clog2(NREGS): address width.
REQ-004 Parameter ZERO_REG, default 1: 1 makes register 0 read as zero and ignore writes.
REQ-005 Parameter BYPASS, default 1: 1 forwards same-cycle write data to the read ports.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 RA  in  AW  read address, port A.
REQ-009 RB  in  AW  read address, port B.
REQ-010 RW  in  AW  write address.
REQ-011 busW  in  WIDTH  write data.
REQ-012 en  in  1  write enable.
REQ-013 set_pend  in  1  mark register SA as pending, i.e. awaiting a write.
REQ-014 SA  in  AW  scoreboard set address.
REQ-015 busA  out  WIDTH  read data, port A.
REQ-016 busB  out  WIDTH  read data, port B.
REQ-017 hazA  out  1  port A reads a pending register.
REQ-018 hazB  out  1  port B reads a pending register.
REQ-019 pend_cnt  out  $clog2(NREGS+1)  number of pending registers.

Function
REQ-020 Storage SHALL be NREGS x WIDTH flops plus an NREGS-bit pending vector pend.
REQ-021 Effective write wv SHALL be en && RW<NREGS && !(ZERO_REG && RW==0).
REQ-022 On a rising edge with wv, reg[RW] SHALL take busW; no other register changes.
REQ-023 Reads SHALL be combinational; an address >=NREGS SHALL read zero; address 0 SHALL read zero when ZERO_REG=1.
REQ-024 When BYPASS=1, wv, and RA==RW, busA SHALL equal busW in the same cycle; the same rule applies to port B with RB.
REQ-025 When BYPASS=0, reads SHALL return pre-edge contents, and written data SHALL be visible from the next cycle.
REQ-026 A rising edge with wv SHALL clear pend[RW].
REQ-027 A rising edge with set_pend, SA<NREGS, and !(ZERO_REG && SA==0) SHALL set pend[SA]; otherwise the set is ignored.
REQ-028 If a set and a clear hit the same register on the same edge, set SHALL win, modelling a new producer.
REQ-029 hazA SHALL be pend[RA] && !(BYPASS && wv && RW==RA); hazB follows the same rule with RB.
REQ-030 hazA/hazB SHALL be 0 for out-of-range or zero-register addresses.
REQ-031 pend_cnt SHALL be registered and equal popcount(pend) after each edge, i.e. one cycle in step with pend.
REQ-032 pend_cnt SHALL never exceed NREGS-ZERO_REG and SHALL never wrap.
REQ-033 Both ports MAY read the same address; each port's behaviour is independent of the other.

Reset
REQ-034 reset low SHALL asynchronously clear all registers, pend, and pend_cnt to 0, regardless of clk.
REQ-035 During reset, busA/busB SHALL read 0 except when bypassed, and hazA/hazB SHALL be 0.
REQ-036 Writes and sets SHALL be ignored while reset is low.
REQ-037 The first write SHALL be honoured on the first rising edge after reset deasserts.

Verification
REQ-038 Reset, then en=1, RW=5, busW=0xDEADBEEF, RA=5 -> busA=0xDEADBEEF in the same cycle (BYPASS=1); reg[5] holds it after the edge.
REQ-039 en=1, RW=0, busW=0x1234, then RA=0 -> busA=0; no pending set on register 0.
REQ-040 set_pend SA=7 -> hazA=1 when RA=7, pend_cnt=1; next cycle en=1, RW=7 -> hazA=0 that cycle, pend_cnt=0 after the edge.
REQ-041 Same edge set_pend SA=3 and en=1 RW=3 -> pend[3]=1 and reg[3] updated.
REQ-042 Fill pending on all of registers 1..31 -> pend_cnt=31, and repeated sets keep it at 31; assert reset mid-sequence -> all outputs 0 immediately.
REQ-043 NREGS=24, WIDTH=16, BYPASS=0: writes to RW=30 are ignored; RA=30 reads 0; a write to register 9 is visible one cycle later.

Source files
------------

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb -- register file with a pending-write scoreboard
//
// An NREGS x WIDTH register file with two combinational read ports and one
// write port. Alongside the data, a one-bit-per-register pending vector
// records which registers are still waiting for an in-flight producer. Each
// read port reports a hazard when it addresses a pending register. A
// registered population count of the pending vector is also provided.
//
// Parameters
//   WIDTH     data bits per register
//   NREGS     number of registers (2..256)
//   AW        address width
//   ZERO_REG  1: register 0 reads as zero, ignores writes and pending sets
//   BYPASS    1: same-cycle write data is forwarded to the read ports
//
// Ports
//   clk       clock; all state updates on the rising edge
//   reset     asynchronous, active-low reset
//   RA, RB    read addresses, ports A and B
//   RW        write address
//   busW      write data
//   en        write enable
//   set_pend  mark register SA as pending
//   SA        scoreboard set address
//   busA/busB read data, ports A and B
//   hazA/hazB read port addresses a pending register
//   pend_cnt  number of pending registers (registered)
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AW-1:0]              RA,
    input  logic [AW-1:0]              RB,
    input  logic [AW-1:0]              RW,
    input  logic [WIDTH-1:0]           busW,
    input  logic                       en,
    input  logic                       set_pend,
    input  logic [AW-1:0]              SA,
    output logic [WIDTH-1:0]           busA,
    output logic [WIDTH-1:0]           busB,
    output logic                       hazA,
    output logic                       hazB,
    output logic [$clog2(NREGS+1)-1:0] pend_cnt
);

    localparam int CW = $clog2(NREGS + 1);

    // NREGS expressed one bit wider than an address so the range compare
    // works even when NREGS is a power of two that fills the address space.
    localparam logic [AW:0] NREGS_X = (AW + 1)'(NREGS);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [CW-1:0]    pend_cnt_q;
    logic [CW-1:0]    pend_cnt_d;

    // -----------------------------------------------------------------------
    // Address qualification
    // -----------------------------------------------------------------------
    // A usable address is inside the array and is not the hardwired zero
    // register. Out-of-range or zero-register addresses never touch state
    // and never read anything but zero.
    logic ra_ok;
    logic rb_ok;
    logic rw_ok;
    logic sa_ok;

    always_comb begin
        ra_ok = ({1'b0, RA} < NREGS_X) && !((ZERO_REG != 0) && (RA == '0));
        rb_ok = ({1'b0, RB} < NREGS_X) && !((ZERO_REG != 0) && (RB == '0));
        rw_ok = ({1'b0, RW} < NREGS_X) && !((ZERO_REG != 0) && (RW == '0));
        sa_ok = ({1'b0, SA} < NREGS_X) && !((ZERO_REG != 0) && (SA == '0));
    end

    // Effective write and effective pending set. These are not gated by
    // reset: while reset is low the flops are held clear anyway, and the
    // write is still allowed to appear on the bypass path.
    logic wv;
    logic sv;

    always_comb begin
        wv = en && rw_ok;
        sv = set_pend && sa_ok;
    end

    // Same-cycle forwarding condition per read port.
    logic fwd_a;
    logic fwd_b;

    always_comb begin
        fwd_a = (BYPASS != 0) && wv && (RA == RW);
        fwd_b = (BYPASS != 0) && wv && (RB == RW);
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wv) begin
            regs_d[RW] = busW;
        end
    end

    // The clear is applied first and the set second, so a set and a clear
    // on the same register in the same cycle leaves it pending: the set
    // stands for a newer producer than the write that is retiring.
    always_comb begin
        pend_d = pend_q;
        if (wv) begin
            pend_d[RW] = 1'b0;
        end
        if (sv) begin
            pend_d[SA] = 1'b1;
        end
    end

    // Counting the next pending vector keeps pend_cnt in step with pend
    // after every edge. Bit 0 is never set when ZERO_REG=1, so the count
    // is bounded by NREGS-ZERO_REG and CW bits always suffice.
    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            pend_cnt_d = pend_cnt_d + CW'(pend_d[i]);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------------
    // Each port is decoded independently; both may address the same
    // register. The forwarded value takes priority over the stored value.
    always_comb begin
        busA = '0;
        if (ra_ok) begin
            if (fwd_a) begin
                busA = busW;
            end else begin
                busA = regs_q[RA];
            end
        end
    end

    always_comb begin
        busB = '0;
        if (rb_ok) begin
            if (fwd_b) begin
                busB = busW;
            end else begin
                busB = regs_q[RB];
            end
        end
    end

    // A pending register that is being written this cycle is not a hazard
    // when the write data is forwarded, since the reader already sees it.
    always_comb begin
        hazA = 1'b0;
        if (ra_ok) begin
            hazA = pend_q[RA] && !fwd_a;
        end
    end

    always_comb begin
        hazB = 1'b0;
        if (rb_ok) begin
            hazB = pend_q[RB] && !fwd_b;
        end
    end

    assign pend_cnt = pend_cnt_q;

endmodule
